// File: rtl/ysyx_bus_arb.sv
// ysyx_bus_arb: shares one non-pipelined downstream AXI4-lite style bus between
// the IFU fetch port and the LSU load/store port. One transaction is in flight at
// a time; the response is returned to whichever port owns it as a one-cycle
// registered pulse. Fixed priority store > load > fetch.
//
// Optional feature: define YSYX_BUS_ARB_STARVE_EN to add a starvation counter
// that forces an IFU grant after STARVE_MAX consecutive LSU grants while the IFU
// is waiting. Without the macro the priority is strictly fixed.
module ysyx_bus_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            ifu_arvalid,
    input  logic [XLEN-1:0] ifu_araddr,
    input  logic            ifu_flush,
    output logic            ifu_bus_ready,
    output logic            ifu_rready,
    output logic [XLEN-1:0] ifu_rdata,

    input  logic            lsu_arvalid,
    input  logic [XLEN-1:0] lsu_araddr,
    input  logic [7:0]      lsu_rstrb,
    output logic            lsu_rvalid,
    output logic [XLEN-1:0] lsu_rdata,
    input  logic            lsu_awvalid,
    input  logic [XLEN-1:0] lsu_awaddr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [7:0]      lsu_wstrb,
    input  logic            lsu_wvalid,
    output logic            lsu_wready,

    output logic            m_arvalid,
    output logic [XLEN-1:0] m_araddr,
    output logic [2:0]      m_arsize,
    input  logic            m_arready,
    input  logic            m_rvalid,
    input  logic [XLEN-1:0] m_rdata,
    input  logic [1:0]      m_rresp,
    output logic            m_rready,
    output logic            m_awvalid,
    output logic [XLEN-1:0] m_awaddr,
    output logic [2:0]      m_awsize,
    input  logic            m_awready,
    output logic            m_wvalid,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_wstrb,
    input  logic            m_wready,
    input  logic            m_bvalid,
    input  logic [1:0]      m_bresp,
    output logic            m_bready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_AR = 3'd1,
        RD_R  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;

    // Captured transaction
    logic            owner_lsu;   // 1: LSU owns the in-flight transaction, 0: IFU
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] rdata_q;

    // Write-channel accept tracking: AW and W may be accepted in different cycles
    logic            aw_done;
    logic            w_done;
    logic            aw_ok;
    logic            w_ok;

    // Set when a fetch in flight is flushed; its response must not reach the IFU
    logic            kill;

    logic            ifu_rready_q;
    logic            lsu_rvalid_q;
    logic            lsu_wready_q;

    logic            store_req;
    logic            load_req;
    logic            fetch_req;
    logic            ifu_force;
    logic            grant_store;
    logic            grant_load;
    logic            grant_fetch;

    // Responses carry no information the requesters use; errors complete normally.
    logic            unused_inputs;
    assign unused_inputs = ^{m_rresp, m_bresp, lsu_wstrb[7:4]};

    // Transfer size from a byte strobe; anything irregular is issued as a word.
    function automatic logic [2:0] strb_size(input logic [7:0] strb);
        case (strb)
            8'h01:   return 3'd0;
            8'h03:   return 3'd1;
            8'h0F:   return 3'd2;
            default: return 3'd2;
        endcase
    endfunction

    assign store_req = lsu_awvalid & lsu_wvalid;
    assign load_req  = lsu_arvalid;
    // A flush in the same cycle as a fetch request cancels that request.
    assign fetch_req = ifu_arvalid & ~ifu_flush;

`ifdef YSYX_BUS_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign ifu_force = (starve_cnt >= CNT_W'(STARVE_MAX));

    // Count LSU grants taken while the IFU is waiting; saturates at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!ifu_arvalid || grant_fetch) begin
            starve_cnt <= '0;
        end else if ((grant_store || grant_load) && !ifu_force) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_starve;
    assign unused_starve = STARVE_MAX;
    assign ifu_force     = 1'b0;
`endif

    // Grant decision in IDLE: forced fetch (starvation), then store > load > fetch.
    always_comb begin
        grant_store = 1'b0;
        grant_load  = 1'b0;
        grant_fetch = 1'b0;
        if (state == IDLE) begin
            if (ifu_force && fetch_req) begin
                grant_fetch = 1'b1;
            end else if (store_req) begin
                grant_store = 1'b1;
            end else if (load_req) begin
                grant_load = 1'b1;
            end else if (fetch_req) begin
                grant_fetch = 1'b1;
            end
        end
    end

    assign ifu_bus_ready = (state == IDLE) && (ifu_force || !(store_req || load_req));

    assign aw_ok = aw_done | m_awready;
    assign w_ok  = w_done  | m_wready;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and downstream handshake outputs.
    always_comb begin
        state_next = state;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_store) begin
                    state_next = WR_AW;
                end else if (grant_load || grant_fetch) begin
                    state_next = RD_AR;
                end
            end
            RD_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_next = IDLE;
                end
            end
            WR_AW: begin
                m_awvalid = ~aw_done;
                m_wvalid  = ~w_done;
                if (aw_ok && w_ok) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch address, data, strobe, size and owner at the moment of grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_lsu <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
        end else if (grant_store) begin
            owner_lsu <= 1'b1;
            addr_q    <= lsu_awaddr;
            wdata_q   <= lsu_wdata;
            wstrb_q   <= lsu_wstrb[3:0];
            size_q    <= strb_size(lsu_wstrb);
        end else if (grant_load) begin
            owner_lsu <= 1'b1;
            addr_q    <= lsu_araddr;
            size_q    <= strb_size(lsu_rstrb);
        end else if (grant_fetch) begin
            owner_lsu <= 1'b0;
            addr_q    <= ifu_araddr;
            size_q    <= 3'd2;
        end
    end

    // Remember which write channels have already handshaked this transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR_AW) begin
            if (aw_ok && w_ok) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_ok;
                w_done  <= w_ok;
            end
        end
    end

    // Kill flag: a flushed fetch still finishes downstream but is not returned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kill <= 1'b0;
        end else if (state_next == IDLE) begin
            kill <= 1'b0;
        end else if ((state == RD_AR || state == RD_R) && !owner_lsu && ifu_flush) begin
            kill <= 1'b1;
        end
    end

    // Capture read data and raise the one-cycle response pulse for the owner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q      <= '0;
            ifu_rready_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
        end else begin
            ifu_rready_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            if (state == RD_R && m_rvalid) begin
                rdata_q <= m_rdata;
                if (owner_lsu) begin
                    lsu_rvalid_q <= 1'b1;
                end else begin
                    ifu_rready_q <= ~kill & ~ifu_flush;
                end
            end
            if (state == WR_B && m_bvalid) begin
                lsu_wready_q <= 1'b1;
            end
        end
    end

    assign m_araddr   = addr_q;
    assign m_arsize   = size_q;
    assign m_awaddr   = addr_q;
    assign m_awsize   = size_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wstrb_q;

    assign ifu_rready = ifu_rready_q;
    assign ifu_rdata  = rdata_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign lsu_rdata  = rdata_q;
    assign lsu_wready = lsu_wready_q;

endmodule

// File: doc/ysyx_bus_arb.md
Name: ysyx_bus_arb

Overview:
- Arbitrates the single downstream memory bus between the IFU read port and the LSU load/store port.
- Issues one transaction at a time, non-pipelined. Routes the response back to the owning requester.
- Sits between IFU/LSU and the SoC AXI4-lite master.
- Drops responses for IFU fetches that were flushed while in flight.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, consecutive LSU grants allowed while IFU waits (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ifu_arvalid  in  1  IFU fetch request
- ifu_araddr  in  XLEN  fetch address
- ifu_flush  in  1  pipeline flush; kills the pending IFU response
- ifu_bus_ready  out  1  arbiter idle; the IFU request will be sampled this cycle
- ifu_rready  out  1  one-cycle pulse, fetch data valid
- ifu_rdata  out  XLEN  fetch data
- lsu_arvalid  in  1  load request
- lsu_araddr  in  XLEN  load address
- lsu_rstrb  in  8  load byte strobe
- lsu_rvalid  out  1  one-cycle pulse, load data valid
- lsu_rdata  out  XLEN  load data
- lsu_awvalid  in  1  store request; lsu_wvalid is asserted with it
- lsu_awaddr  in  XLEN  store address
- lsu_wdata  in  XLEN  store data
- lsu_wstrb  in  8  store byte strobe
- lsu_wvalid  in  1  store data valid
- lsu_wready  out  1  one-cycle pulse, store completed
- m_arvalid/m_araddr/m_arsize  out  1/XLEN/3  downstream read address
- m_arready  in  1  downstream read address accepted
- m_rvalid/m_rdata/m_rresp  in  1/XLEN/2  downstream read data
- m_rready  out  1  downstream read data accepted
- m_awvalid/m_awaddr/m_awsize  out  1/XLEN/3  downstream write address
- m_awready  in  1  downstream write address accepted
- m_wvalid/m_wdata/m_wstrb  out  1/XLEN/4  downstream write data
- m_wready  in  1  downstream write data accepted
- m_bvalid/m_bresp  in  1/2  downstream write response
- m_bready  out  1  downstream write response accepted

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all m_*valid, m_*ready and upstream response pulses = 0.
  - Captured address/data registers = 0; kill flag = 0.
- States: IDLE, RD_AR, RD_R, WR_AW, WR_B.
- Owner register: IFU or LSU.
- Grant in IDLE, evaluated every cycle, fixed priority store > load > fetch:
  - lsu_awvalid&lsu_wvalid -> WR_AW.
  - else lsu_arvalid -> RD_AR, owner = LSU.
  - else ifu_arvalid -> RD_AR, owner = IFU.
  - Address, data, strobe and size are latched on grant.
- ifu_bus_ready = (state == IDLE) and no LSU request this cycle.
- Size encoding from strobe: 0x1 -> 0, 0x3 -> 1, 0xF -> 2, other -> 2. IFU fetches always use size 2.
- RD_AR: m_arvalid = 1; m_arready -> RD_R.
- RD_R: m_rready = 1. On m_rvalid:
  - Latch rdata, return to IDLE.
  - Next cycle pulse ifu_rready or lsu_rvalid (registered, latency 1), according to owner.
- WR_AW:
  - m_awvalid and m_wvalid asserted together; each drops independently once its ready has been seen.
  - When both have been accepted (same or different cycles) -> WR_B.
- WR_B: m_bready = 1; m_bvalid -> IDLE and lsu_wready pulses the next cycle.
- Flush:
  - ifu_flush while owner = IFU in RD_AR/RD_R sets the kill flag. The downstream transaction still completes; ifu_rready is suppressed; kill clears on return to IDLE.
  - ifu_flush in IDLE blocks the grant of a simultaneous ifu_arvalid.
- Error responses: nonzero m_rresp/m_bresp are treated as normal completion.
- Minimum latency, request to response pulse: 3 cycles with zero-wait slave.
- Back-to-back grants: a new grant is allowed in the cycle after returning to IDLE.
- Mid-transaction reset: all state is dropped immediately; no response pulse is emitted.

Optional Feature:
- Macro: YSYX_BUS_ARB_STARVE_EN.
- When defined: a starve counter increments on each LSU grant while ifu_arvalid is held, and clears on an IFU grant or when ifu_arvalid = 0. At STARVE_MAX the next IDLE grant goes to the IFU regardless of LSU requests; ifu_bus_ready ignores LSU requests in that cycle.
- When undefined: strict fixed priority, no counter logic.

Test Plan:
- Lone fetch: ifu_arvalid, araddr 0x3000_0000, slave returns 0x0000_0413 with zero wait -> m_arsize = 2, ifu_rready pulse with rdata 0x0000_0413 exactly 3 cycles after request.
- Store wins over fetch: simultaneous lsu_awvalid+wvalid (addr 0x8000_0010, data 0xDEAD_BEEF, wstrb 0xF) and ifu_arvalid -> write issued first with m_wstrb 0xF; fetch granted in the cycle after lsu_wready.
- Split AW/W accept: m_awready in cycle 1, m_wready in cycle 3 -> m_awvalid drops after cycle 1; WR_B entered only after cycle 3; one lsu_wready pulse.
- Byte load: lsu_rstrb 0x01 at 0x8000_0003 -> m_arsize = 0, lsu_rvalid with slave data; ifu_rready stays 0.
- Flush in flight: fetch issued, ifu_flush in RD_R, slave rvalid 2 cycles later -> no ifu_rready pulse; next fetch completes normally.
- Starvation (macro on, STARVE_MAX = 4): continuous lsu_arvalid plus ifu_arvalid -> IFU granted after the 4th LSU load; without the macro, IFU is never granted.
